// File: rtl/logic_accumulator_pkg.sv
// Shared types for the multi-operand logic stage: operation codes, FSM states
// and the per-operation fold identity.
package logic_pkg;

    // Widest operand the identity helper can produce; callers size-cast down to WIDTH.
    localparam int ID_W = 1024;

    typedef enum logic [1:0] {
        OP_OR  = 2'b00,
        OP_AND = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } logic_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // NOR folds as OR and is inverted only at finalisation, so it shares OR's identity.
    function automatic logic [ID_W-1:0] identity(input logic_op_e op);
        logic [ID_W-1:0] id;
        id = (op == OP_AND) ? '1 : '0;
        return id;
    endfunction

endpackage

// File: rtl/logic_accumulator_op.sv
// Combinational WIDTH-bit bitwise unit; the generalised 2-input gate used for the fold.
module logic_op
    import logic_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic_op_e        op,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_OR:   y = a | b;
            OP_AND:  y = a & b;
            OP_XOR:  y = a ^ b;
            default: y = ~(a | b);
        endcase
    end

endmodule

// File: rtl/logic_accumulator.sv
// Folds a frame of len operands into one result with OR/AND/XOR/NOR and
// presents it with registered any/all flags on a valid/ready output.
//
// state | meaning
// IDLE  | waiting for start; no handshakes active
// ACCUM | accepting operands, one fold per beat
// HOLD  | result registered and offered until out_ready
module logic_accumulator
    import logic_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int MAX_LEN = 16,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_any,
    output logic             out_all,
    output logic             busy
);

    state_e           state_q, state_d;
    logic_op_e        op_q, op_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             any_q, any_d;
    logic             all_q, all_d;

    logic_op_e        op_in;
    logic [LEN_W-1:0] len_clamped;
    logic [WIDTH-1:0] id_val;
    logic [WIDTH-1:0] id_final;
    logic_op_e        fold_op;
    logic [WIDTH-1:0] fold_y;
    logic [WIDTH-1:0] fold_final;
    logic             last_beat;

    assign op_in       = logic_op_e'(op);
    assign len_clamped = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    assign id_val      = WIDTH'(identity(op_in));
    assign id_final    = (op_in == OP_NOR) ? ~id_val : id_val;

    // NOR accumulates as OR; the inversion is applied once when the result is registered.
    assign fold_op     = (op_q == OP_NOR) ? OP_OR : op_q;
    assign fold_final  = (op_q == OP_NOR) ? ~fold_y : fold_y;
    assign last_beat   = (count_q == len_q - LEN_W'(1));

    logic_op #(.WIDTH(WIDTH)) u_fold (
        .a  (acc_q),
        .b  (in_data),
        .op (fold_op),
        .y  (fold_y)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        len_d   = len_q;
        count_d = count_q;
        acc_d   = acc_q;
        res_d   = res_q;
        any_d   = any_q;
        all_d   = all_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d = op_in;
                    if (len_clamped != '0) begin
                        len_d   = len_clamped;
                        acc_d   = id_val;
                        count_d = '0;
                        state_d = ACCUM;
                    end else begin
                        res_d   = id_final;
                        any_d   = |id_final;
                        all_d   = &id_final;
                        state_d = HOLD;
                    end
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d   = fold_y;
                    count_d = count_q + LEN_W'(1);
                    if (last_beat) begin
                        res_d   = fold_final;
                        any_d   = |fold_final;
                        all_d   = &fold_final;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_OR;
            len_q   <= '0;
            count_q <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            any_q   <= 1'b0;
            all_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            len_q   <= len_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            any_q   <= any_d;
            all_q   <= all_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign out_data  = res_q;
    assign out_any   = any_q;
    assign out_all   = all_q;

endmodule

// File: tb/tb_logic_accumulator.sv
// Directed bench for logic_accumulator: expected results are queued at frame
// start and a negedge monitor compares them at each output handshake.
module tb_logic_accumulator;

    localparam int WIDTH   = 8;
    localparam int MAX_LEN = 16;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [1:0]       op;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_any;
    logic             out_all;
    logic             busy;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             any;
        logic             all;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    logic_accumulator #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_any   (out_any),
        .out_all   (out_all),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Inputs only change at posedge+1, so out_ready is stable when sampled here.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL sb_unexpected: result 0x%0h, expected no result", out_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_data", 32'(out_data), 32'(e.d));
                chk("out_any",  32'(out_any),  32'(e.any));
                chk("out_all",  32'(out_all),  32'(e.all));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] d, input logic a, input logic l);
        exp_t e;
        e.d = d; e.any = a; e.all = l;
        sb.push_back(e);
    endtask

    task automatic do_start(input logic [1:0] o, input int n);
        start = 1'b1;
        op    = o;
        len   = LEN_W'(n);
        cyc();
        start = 1'b0;
        op    = 2'b00;
        len   = '0;
        chk("start_in_ready", 32'(in_ready), (n > 0) ? 32'd1 : 32'd0);
        chk("start_busy", 32'(busy), 32'd1);
    endtask

    task automatic beat(input logic [WIDTH-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        cyc();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; len = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'h00);
        chk("rst_busy",      32'(busy),      32'd0);

        // OR, len 3, back-to-back beats
        push(8'h91, 1'b1, 1'b0);
        do_start(2'b00, 3);
        beat(8'h01);
        beat(8'h10);
        chk("or_valid_early", 32'(out_valid), 32'd0);
        beat(8'h80);
        chk("or_latency", 32'(out_valid), 32'd1);
        cyc();
        chk("or_idle", 32'(busy), 32'd0);

        // AND, len 3, two idle cycles carrying junk data between beats 1 and 2
        push(8'h30, 1'b1, 1'b0);
        do_start(2'b01, 3);
        beat(8'hFF);
        in_data = 8'h00;
        cyc(); cyc();
        in_data = '0;
        chk("and_gap_ready", 32'(in_ready), 32'd1);
        beat(8'hF0);
        chk("and_gap_count", 32'(out_valid), 32'd0);
        beat(8'h3C);
        chk("and_latency", 32'(out_valid), 32'd1);
        cyc();

        // XOR, len 3
        push(8'h00, 1'b0, 1'b0);
        do_start(2'b10, 3);
        beat(8'hAA);
        beat(8'h55);
        beat(8'hFF);
        chk("xor_latency", 32'(out_valid), 32'd1);
        cyc();

        // NOR, len 2
        push(8'hFF, 1'b1, 1'b1);
        do_start(2'b11, 2);
        beat(8'h00);
        beat(8'h00);
        chk("nor_latency", 32'(out_valid), 32'd1);
        cyc();

        // OR, len 0: result straight after start
        push(8'h00, 1'b0, 1'b0);
        do_start(2'b00, 0);
        chk("len0_valid", 32'(out_valid), 32'd1);
        cyc();
        chk("len0_idle", 32'(busy), 32'd0);

        // Backpressure in HOLD with a stray start
        out_ready = 1'b0;
        push(8'h5A, 1'b1, 1'b0);
        do_start(2'b00, 1);
        beat(8'h5A);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                start = 1'b1; op = 2'b01; len = LEN_W'(3);
            end
            cyc();
            start = 1'b0; op = 2'b00; len = '0;
            chk("bp_data",     32'(out_data),  32'h5A);
            chk("bp_valid",    32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        cyc();
        chk("bp_release_busy", 32'(busy), 32'd0);
        cyc();
        chk("bp_start_ignored", 32'(busy), 32'd0);

        // Reset mid-frame, then a clean frame
        do_start(2'b00, 2);
        beat(8'hAA);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("abort_in_ready",  32'(in_ready),  32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_out_data",  32'(out_data),  32'h00);
        push(8'hFF, 1'b1, 1'b1);
        do_start(2'b00, 2);
        beat(8'h0F);
        beat(8'hF0);
        chk("fresh_latency", 32'(out_valid), 32'd1);
        cyc();
        cyc();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
